// File: rtl/fifo_drain.sv
// Burst drain engine: pops burst_len words from a registered-read FIFO and
// forwards them on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, issued_q, rd_count_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic                  xfer;
  logic [1:0]            pending;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (burst_len == '0) ? DONE : RUN;
      RUN:  if (xfer && ((rd_count_q + CNT_WIDTH'(1)) == len_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The word leaving this cycle frees its slot before the next pop can land,
  // which keeps back-to-back pops going at one word per cycle.
  always_comb begin
    m_valid   = (occ_q != 2'd0);
    xfer      = m_valid && m_ready;
    pending   = occ_q - {1'b0, xfer} + {1'b0, inflight_q};
    fifo_r_en = (state_q == RUN) && !fifo_empty && (issued_q < len_q) && (pending < 2'd2);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    m_data    = buf0_q;
    rd_count  = rd_count_q;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      inflight_q <= fifo_r_en;
      if (state_q == IDLE && start) begin
        len_q      <= burst_len;
        issued_q   <= '0;
        rd_count_q <= '0;
      end
      if (fifo_r_en) issued_q <= issued_q + CNT_WIDTH'(1);
      if (xfer) rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      unique case ({inflight_q, xfer})
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= fifo_r_data;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_r_data;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= fifo_r_data;
          else               buf1_q <= fifo_r_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural registered-read FIFO on the read
// side, hand-computed expected stream words and control flags.
module tb_fifo_drain;

  logic       r_clk = 1'b0;
  logic       r_rst, start, fifo_r_en, m_valid, m_ready, busy, done;
  logic       fifo_empty;
  logic [7:0] burst_len, m_data, rd_count;
  logic [7:0] fifo_r_data = 8'd0;

  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  int         pops = 0;
  int         done_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         base;

  always #5 r_clk = ~r_clk;

  fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .start       (start),
    .burst_len   (burst_len),
    .fifo_empty  (fifo_empty),
    .fifo_r_en   (fifo_r_en),
    .fifo_r_data (fifo_r_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .rd_count    (rd_count)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_r_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 6'd1;
      pops        <= pops + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge r_clk);
  endtask

  task automatic push(input int v);
    mem[wr_ptr] = 8'(v);
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    burst_len = 8'(len);
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, int'(m_valid), 1);
  endtask

  task automatic expect_word(input string tag, input int v);
    check({tag, "_valid"}, int'(m_valid), 1);
    check({tag, "_data"}, int'(m_data), v);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    r_rst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(rd_count), 0);
    check("rst_ren", int'(fifo_r_en), 0);
    check("rst_data", int'(m_data), 0);
    r_rst = 1'b0;
    tick();

    // Full-rate burst of 16.
    for (int v = 1; v <= 16; v++) push(v);
    m_ready = 1'b1;
    do_start(16);
    wait_valid("t1_wait");
    for (int k = 1; k <= 16; k++) expect_word("t1", k);
    check("t1_done", int'(done), 1);
    check("t1_count", int'(rd_count), 16);
    tick();
    check("t1_done_off", int'(done), 0);
    check("t1_idle", int'(busy), 0);
    check("t1_hold", int'(rd_count), 16);

    // Backpressure: only two pops while the sink is stalled.
    base = pops;
    for (int v = 1; v <= 4; v++) push(v);
    m_ready = 1'b0;
    do_start(4);
    repeat (6) tick();
    check("t2_pops2", pops - base, 2);
    check("t2_ren", int'(fifo_r_en), 0);
    check("t2_valid", int'(m_valid), 1);
    check("t2_data", int'(m_data), 1);
    repeat (3) tick();
    check("t2_stable", int'(m_data), 1);
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) expect_word("t2", k);
    check("t2_done", int'(done), 1);
    check("t2_count", int'(rd_count), 4);
    check("t2_pops4", pops - base, 4);
    tick();

    // FIFO underrun mid-burst, then refill.
    base = done_cnt;
    push(1); push(2);
    do_start(5);
    wait_valid("t3_wait_a");
    expect_word("t3", 1);
    expect_word("t3", 2);
    repeat (4) tick();
    check("t3_busy", int'(busy), 1);
    check("t3_stall_valid", int'(m_valid), 0);
    check("t3_stall_ren", int'(fifo_r_en), 0);
    check("t3_stall_done", int'(done), 0);
    push(3); push(4); push(5);
    wait_valid("t3_wait_b");
    for (int k = 3; k <= 5; k++) expect_word("t3", k);
    check("t3_done", int'(done), 1);
    check("t3_count", int'(rd_count), 5);
    tick();
    check("t3_done_once", done_cnt - base, 1);

    // Zero-length burst.
    base = pops;
    do_start(0);
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 1);
    check("t4_ren", int'(fifo_r_en), 0);
    check("t4_count", int'(rd_count), 0);
    tick();
    check("t4_done_off", int'(done), 0);
    check("t4_idle", int'(busy), 0);
    check("t4_nopop", pops - base, 0);

    // Reset after 3 transfers; words 14..16 are popped and discarded.
    for (int v = 11; v <= 20; v++) push(v);
    do_start(8);
    wait_valid("t5_wait_a");
    for (int k = 11; k <= 13; k++) expect_word("t5", k);
    check("t5_count3", int'(rd_count), 3);
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    check("t5_rst_valid", int'(m_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_count", int'(rd_count), 0);
    check("t5_rst_data", int'(m_data), 0);
    do_start(2);
    wait_valid("t5_wait_b");
    expect_word("t5_after", 17);
    expect_word("t5_after", 18);
    check("t5_done", int'(done), 1);
    check("t5_count2", int'(rd_count), 2);
    tick();

    // start during RUN is ignored.
    base = pops;
    for (int v = 21; v <= 26; v++) push(v);
    do_start(3);
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0;
    wait_valid("t6_wait");
    expect_word("t6", 19);
    expect_word("t6", 20);
    expect_word("t6", 21);
    check("t6_done", int'(done), 1);
    check("t6_count", int'(rd_count), 3);
    repeat (3) tick();
    check("t6_idle", int'(busy), 0);
    check("t6_pops", pops - base, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
